// File: rtl/matmul_pkg.sv
// Shared constants, serializer state type and slice helper for the 3x3 array multiplier.
// Used by the input stage and by matrix_result_serializer / result_byte_mux.
package matmul_pkg;

   localparam int N_ELEM     = 9;
   localparam int ELEM_W     = 18;
   localparam int BPE        = (ELEM_W + 7) / 8;
   localparam int N_BYTES    = N_ELEM * BPE;
   localparam int FLAT_W     = N_ELEM * ELEM_W;
   localparam int ELEM_IDX_W = $clog2(N_ELEM);
   localparam int BYTE_IDX_W = $clog2(BPE);

   localparam logic [ELEM_IDX_W-1:0] LAST_ELEM = ELEM_IDX_W'(N_ELEM - 1);
   localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BPE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } ser_state_t;

   // Bit offset of byte byte_idx of element elem inside a packed row-major matrix.
   function automatic int unsigned slice_lsb(input int unsigned elem, input int unsigned byte_idx);
      return elem * ELEM_W + byte_idx * 8;
   endfunction

endpackage

// File: rtl/result_byte_mux.sv
// Combinational selector: one zero-padded byte of one element of the captured result matrix.
// Zero latency, no flow control; out-of-range indices yield 8'h00.
module result_byte_mux
   import matmul_pkg::*;
(
   input  logic [FLAT_W-1:0]     cap,
   input  logic [ELEM_IDX_W-1:0] elem_idx,
   input  logic [BYTE_IDX_W-1:0] byte_idx,
   output logic [7:0]            byte_out
);

   logic [BPE*8-1:0] padded [N_ELEM];

   for (genvar e = 0; e < N_ELEM; e++) begin : g_pad
      assign padded[e] = {{(BPE*8-ELEM_W){1'b0}}, cap[slice_lsb(e, 0) +: ELEM_W]};
   end

   always_comb begin
      byte_out = 8'h00;
      for (int e = 0; e < N_ELEM; e++) begin
         for (int b = 0; b < BPE; b++) begin
            if (elem_idx == ELEM_IDX_W'(e) && byte_idx == BYTE_IDX_W'(b)) begin
               byte_out = padded[e][b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/matrix_result_serializer.sv
// Captures the 3x3 product matrix on start and streams it little-endian, one byte per ready cycle;
// first byte one cycle after capture, outputs registered and held while stalled. Option: RESULT_SERIALIZER_CHECKSUM_EN.
module matrix_result_serializer
   import matmul_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [FLAT_W-1:0] c_flat,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              done
);

   ser_state_t            state;
   logic [FLAT_W-1:0]     cap_reg;
   logic [ELEM_IDX_W-1:0] elem_cnt;
   logic [BYTE_IDX_W-1:0] byte_cnt;

   logic [ELEM_IDX_W-1:0] nxt_elem;
   logic [BYTE_IDX_W-1:0] nxt_byte;
   logic [FLAT_W-1:0]     mux_src;
   logic [ELEM_IDX_W-1:0] mux_elem;
   logic [BYTE_IDX_W-1:0] mux_byte_idx;
   logic [7:0]            mux_out;
   logic                  last_data;

`ifdef RESULT_SERIALIZER_CHECKSUM_EN
   logic [7:0] csum;
   logic       csum_phase;
`endif

   always_comb begin
      last_data = (elem_cnt == LAST_ELEM) && (byte_cnt == LAST_BYTE);
      if (byte_cnt == LAST_BYTE) begin
         nxt_byte = '0;
         nxt_elem = elem_cnt + ELEM_IDX_W'(1);
      end else begin
         nxt_byte = byte_cnt + BYTE_IDX_W'(1);
         nxt_elem = elem_cnt;
      end
      // On capture the register is not loaded yet, so byte 0 comes from the live input.
      if (state == IDLE) begin
         mux_src      = c_flat;
         mux_elem     = '0;
         mux_byte_idx = '0;
      end else begin
         mux_src      = cap_reg;
         mux_elem     = nxt_elem;
         mux_byte_idx = nxt_byte;
      end
   end

   result_byte_mux u_byte_mux (
      .cap      (mux_src),
      .elem_idx (mux_elem),
      .byte_idx (mux_byte_idx),
      .byte_out (mux_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cap_reg   <= '0;
         elem_cnt  <= '0;
         byte_cnt  <= '0;
         out_data  <= 8'h00;
         out_valid <= 1'b0;
         done      <= 1'b0;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
         csum       <= 8'h00;
         csum_phase <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cap_reg   <= c_flat;
                  elem_cnt  <= '0;
                  byte_cnt  <= '0;
                  out_data  <= mux_out;
                  out_valid <= 1'b1;
                  state     <= SEND;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
                  csum       <= 8'h00;
                  csum_phase <= 1'b0;
`endif
               end
            end
            SEND: begin
               if (out_ready) begin
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
                  csum <= csum ^ out_data;
                  if (csum_phase) begin
                     state     <= DONE;
                     out_valid <= 1'b0;
                     out_data  <= 8'h00;
                     done      <= 1'b1;
                     elem_cnt  <= '0;
                     byte_cnt  <= '0;
                  end else if (last_data) begin
                     // Trailer byte: running XOR folded with the data byte leaving now.
                     csum_phase <= 1'b1;
                     out_data   <= csum ^ out_data;
                  end else begin
                     elem_cnt <= nxt_elem;
                     byte_cnt <= nxt_byte;
                     out_data <= mux_out;
                  end
`else
                  if (last_data) begin
                     state     <= DONE;
                     out_valid <= 1'b0;
                     out_data  <= 8'h00;
                     done      <= 1'b1;
                     elem_cnt  <= '0;
                     byte_cnt  <= '0;
                  end else begin
                     elem_cnt <= nxt_elem;
                     byte_cnt <= nxt_byte;
                     out_data <= mux_out;
                  end
`endif
               end
            end
            DONE: begin
               if (!start) begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               out_data  <= 8'h00;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule
